// File: rtl/seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// seq_pattern_detector
//
// Parametrised serial pattern detector. This block replaces the fixed 3-bit
// "100" detector. The pattern length is fixed at build time. The pattern
// value is loaded at run time.
//
// Valid bits shift into a history register, newest bit at bit 0. After
// PAT_LEN bits have been collected, every new valid bit is compared against
// the loaded pattern. A hit produces a registered one-cycle pulse on `out`.
// A hit also bumps a saturating match counter.
//
// Optional build macro: SEQ_DET_MASK_EN
//   When defined, the block adds a per-bit don't-care mask (pattern_mask).
//   The mask is latched together with the pattern.
//   When undefined, a hit requires an exact compare.
//
// Handshake: serialInput is consumed only on a rising clk edge where
//   in_valid=1. There is no back-pressure; the block is always ready.
//   pattern_load wins over a same-edge valid bit, and that bit is dropped.
//
// Ports:
//   clk           system clock; all state changes on the rising edge
//   reset         asynchronous, active-high reset
//   serialInput   serial data bit
//   in_valid      qualifies serialInput
//   pattern       pattern value; pattern[PAT_LEN-1] matches the oldest bit
//   pattern_mask  (SEQ_DET_MASK_EN only) 1 = compare bit, 0 = don't care
//   pattern_load  latch pattern (and mask), clear history, restart search
//   overlap_en    1 = keep history after a hit; 0 = restart after a hit
//   count_clear   synchronous clear of match_count (wins over increment)
//   out           one-cycle registered match pulse
//   match_count   saturating number of matches
//   armed         high while the FSM is in SEARCH
//   dbg_state_o   FSM state (0 = IDLE, 1 = FILL, 2 = SEARCH)
//   dbg_fill_o    fill counter, zero-extended
// ---------------------------------------------------------------------------
module seq_pattern_detector #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               serialInput,
  input  logic               in_valid,
  input  logic [PAT_LEN-1:0] pattern,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_LEN-1:0] pattern_mask,
`endif
  input  logic               pattern_load,
  input  logic               overlap_en,
  input  logic               count_clear,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed,
  output logic [1:0]         dbg_state_o,
  output logic [4:0]         dbg_fill_o
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    SEARCH = 2'd2
  } state_t;

  state_t             state_q;
  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-1:0] hist_q;
  logic [FILL_W-1:0]  fill_q;
  logic               out_q;
  logic [CNT_W-1:0]   count_q;

  logic [PAT_LEN-1:0] hist_d;
  logic               completing;
  logic               cmp_ok;
  logic               hit;

`ifdef SEQ_DET_MASK_EN
  logic [PAT_LEN-1:0] mask_q;
`endif

  // The history value this bit would produce, and whether that value hits.
  // A hit needs a full window. The window is full when we are already in
  // SEARCH, or when this bit is the last one needed to fill it.
  always_comb begin
    hist_d     = {hist_q[PAT_LEN-2:0], serialInput};
    completing = (state_q == SEARCH) ||
                 ((state_q == FILL) && (fill_q == FILL_LAST));
`ifdef SEQ_DET_MASK_EN
    cmp_ok     = (((hist_d ^ pat_q) & mask_q) == '0);
`else
    cmp_ok     = (hist_d == pat_q);
`endif
    hit        = in_valid && !pattern_load && completing && cmp_ok;
  end

  // Main FSM.
  // pattern_load is checked first so that a reload always drops the
  // same-edge bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      out_q   <= 1'b0;
`ifdef SEQ_DET_MASK_EN
      mask_q  <= '1;
`endif
    end else begin
      out_q <= hit;
      if (pattern_load) begin
        pat_q   <= pattern;
`ifdef SEQ_DET_MASK_EN
        mask_q  <= pattern_mask;
`endif
        hist_q  <= '0;
        fill_q  <= '0;
        state_q <= FILL;
      end else if (in_valid && (state_q != IDLE)) begin
        if (hit && !overlap_en) begin
          // Non-overlapping mode: the next match needs a fresh window.
          hist_q  <= '0;
          fill_q  <= '0;
          state_q <= FILL;
        end else if (completing) begin
          hist_q  <= hist_d;
          fill_q  <= FILL_FULL;
          state_q <= SEARCH;
        end else begin
          hist_q  <= hist_d;
          fill_q  <= fill_q + 1'b1;
          state_q <= FILL;
        end
      end
    end
  end

  // Saturating match counter.
  // A clear wins over a same-edge hit. A pattern reload leaves the count
  // unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (count_clear) begin
      count_q <= '0;
    end else if (hit && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign out         = out_q;
  assign match_count = count_q;
  assign armed       = (state_q == SEARCH);
  assign dbg_state_o = state_q;
  assign dbg_fill_o  = 5'(fill_q);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_detector
//
// Two detector instances share one input stream:
//   - u_dut3 is built with PAT_LEN = 3.
//   - u_dut4 is built with PAT_LEN = 4.
// Each instance has its own pattern input.
//
// The reference model works on the valid bits seen since the last restart:
//   - It counts those bits.
//   - It keeps the last L bits as an integer.
//   - A match is the last L bits equal to the pattern under the mask, once
//     at least L bits have been seen.
// ---------------------------------------------------------------------------
module tb_seq_pattern_detector;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       sin = 1'b0;
  logic       vld = 1'b0;
  logic       pld = 1'b0;
  logic       ovl = 1'b1;
  logic       clr = 1'b0;
  logic [2:0] pat3 = '0;
  logic [3:0] pat4 = '0;
  logic [2:0] mask3 = 3'b111;
  logic [3:0] mask4 = 4'b1111;

  logic       out3;
  logic       out4;
  logic       armed3;
  logic       armed4;
  logic [7:0] cnt3;
  logic [7:0] cnt4;
  logic [1:0] st3;
  logic [1:0] st4;
  logic [4:0] fill3;
  logic [4:0] fill4;

  seq_pattern_detector #(.PAT_LEN(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .reset(reset), .serialInput(sin), .in_valid(vld),
    .pattern(pat3),
`ifdef SEQ_DET_MASK_EN
    .pattern_mask(mask3),
`endif
    .pattern_load(pld), .overlap_en(ovl), .count_clear(clr),
    .out(out3), .match_count(cnt3), .armed(armed3),
    .dbg_state_o(st3), .dbg_fill_o(fill3)
  );

  seq_pattern_detector #(.PAT_LEN(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .serialInput(sin), .in_valid(vld),
    .pattern(pat4),
`ifdef SEQ_DET_MASK_EN
    .pattern_mask(mask4),
`endif
    .pattern_load(pld), .overlap_en(ovl), .count_clear(clr),
    .out(out4), .match_count(cnt4), .armed(armed4),
    .dbg_state_o(st4), .dbg_fill_o(fill4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int pulses3 = 0;
  logic [0:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          len_m[2] = '{3, 4};
  bit          started[2];
  int          seen[2];
  int unsigned recent[2];
  int unsigned pat_m[2];
  int unsigned mask_m[2];
  int unsigned cnt_m[2];
  bit          hit_m[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      started[m] = 0;
      seen[m]    = 0;
      recent[m]  = 0;
      pat_m[m]   = 0;
      mask_m[m]  = (1 << len_m[m]) - 1;
      cnt_m[m]   = 0;
      hit_m[m]   = 0;
    end
  endtask

  // One rising clock edge for model m, using the inputs that are currently
  // driven. The expected out bit is pushed onto the scoreboard queue.
  task automatic model_edge(input int m);
    int unsigned lmask;
    lmask    = (1 << len_m[m]) - 1;
    hit_m[m] = 0;
    if (pld) begin
      started[m] = 1;
      seen[m]    = 0;
      recent[m]  = 0;
      pat_m[m]   = (m == 0) ? 32'(pat3) : 32'(pat4);
`ifdef SEQ_DET_MASK_EN
      mask_m[m]  = (m == 0) ? 32'(mask3) : 32'(mask4);
`endif
    end else if (started[m] && vld) begin
      recent[m] = ((recent[m] * 2) + 32'(sin)) & lmask;
      if (seen[m] < len_m[m]) seen[m]++;
      if ((seen[m] == len_m[m]) && (((recent[m] ^ pat_m[m]) & mask_m[m]) == 0))
        hit_m[m] = 1;
      if (hit_m[m] && !ovl) begin
        seen[m]   = 0;
        recent[m] = 0;
      end
    end
    if (clr) cnt_m[m] = 0;
    else if (hit_m[m] && cnt_m[m] < 255) cnt_m[m]++;
    exp_q.push_back(hit_m[m]);
  endtask

  function automatic int exp_state(input int m);
    if (!started[m]) return 0;
    return (seen[m] == len_m[m]) ? 2 : 1;
  endfunction

  task automatic compare_all();
    logic [0:0] e3;
    logic [0:0] e4;
    e3 = exp_q.pop_front();
    e4 = exp_q.pop_front();
    check_eq("out3", 32'(out3), 32'(e3));
    check_eq("cnt3", 32'(cnt3), cnt_m[0]);
    check_eq("armed3", 32'(armed3), 32'(exp_state(0) == 2));
    check_eq("state3", 32'(st3), exp_state(0));
    check_eq("fill3", 32'(fill3), seen[0]);
    check_eq("out4", 32'(out4), 32'(e4));
    check_eq("cnt4", 32'(cnt4), cnt_m[1]);
    check_eq("armed4", 32'(armed4), 32'(exp_state(1) == 2));
    check_eq("state4", 32'(st4), exp_state(1));
    check_eq("fill4", 32'(fill4), seen[1]);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic b, input logic v, input logic ld,
                      input logic cl);
    @(negedge clk);
    sin = b;
    vld = v;
    pld = ld;
    clr = cl;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
    if (out3) pulses3++;
  endtask

  task automatic load(input logic [2:0] p3, input logic [3:0] p4);
    pat3 = p3;
    pat4 = p4;
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic stream(input logic [15:0] bits, input int n);
    logic [15:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) step(b[i], 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #1 reset = 1'b1;
    #1;
    check_eq("rst_out3", 32'(out3), 0);
    check_eq("rst_cnt3", 32'(cnt3), 0);
    check_eq("rst_armed3", 32'(armed3), 0);
    check_eq("rst_state4", 32'(st4), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Bits sent before any load must be ignored.
    stream(16'b101, 3);

    // Legacy equivalence: "100" pattern, overlapping.
    ovl = 1'b1;
    load(3'b100, 4'b1000);
    stream(16'b1001000, 7);
    check_eq("legacy_cnt3", 32'(cnt3), 2);

    // Overlap on: pattern 1010.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load(3'b101, 4'b1010);
    stream(16'b101010, 6);
    check_eq("ovl_on_cnt4", 32'(cnt4), 2);

    // Overlap off, same stream.
    ovl = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load(3'b101, 4'b1010);
    stream(16'b101010, 6);
    check_eq("ovl_off_cnt4", 32'(cnt4), 1);
    check_eq("ovl_off_state4", 32'(st4), 1);
    check_eq("ovl_off_fill4", 32'(fill4), 2);

    // Gaps in in_valid between the bits of "100".
    ovl = 1'b1;
    load(3'b100, 4'b0100);
    pulses3 = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("gap_final_out3", 32'(out3), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("gap_after_out3", 32'(out3), 0);
    check_eq("gap_pulses3", pulses3, 1);

    // pattern_load on the same edge as a completing bit.
    load(3'b100, 4'b1000);
    stream(16'b10, 2);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("ldprio_out3", 32'(out3), 0);
    check_eq("ldprio_armed3", 32'(armed3), 0);
    check_eq("ldprio_fill3", 32'(fill3), 0);

    // count_clear on the same edge as a hit.
    stream(16'b10, 2);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("clrprio_out3", 32'(out3), 1);
    check_eq("clrprio_cnt3", 32'(cnt3), 0);

    // Saturation at 255.
    load(3'b000, 4'b0000);
    for (int i = 0; i < 262; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("sat_cnt3", 32'(cnt3), 255);
    check_eq("sat_cnt4", 32'(cnt4), 255);

    // Asynchronous reset in the middle of a stream.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_eq("arst_out3", 32'(out3), 0);
    check_eq("arst_cnt3", 32'(cnt3), 0);
    check_eq("arst_armed3", 32'(armed3), 0);
    check_eq("arst_cnt4", 32'(cnt4), 0);
    @(negedge clk);
    reset = 1'b0;
    stream(16'b0000, 4);
    check_eq("arst_noload_armed4", 32'(armed4), 0);

`ifdef SEQ_DET_MASK_EN
    // Masked compare: only the outer bits of 1001 matter.
    ovl = 1'b0;
    mask3 = 3'b101;
    mask4 = 4'b1001;
    load(3'b101, 4'b1001);
    stream(16'b1111, 4);
    check_eq("mask_1111_out4", 32'(out4), 1);
    stream(16'b1001, 4);
    check_eq("mask_1001_out4", 32'(out4), 1);
    mask3 = 3'b111;
    mask4 = 4'b1111;
`endif

    // Randomised traffic against the model.
    load(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 600; i++) begin
      logic ld;
      ld = ($urandom_range(0, 29) == 0);
      if (ld) begin
        pat3 = 3'($urandom_range(0, 7));
        pat4 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 9) == 0) ovl = ~ovl;
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ld,
           ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout got=stalled exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised serial pattern detector; successor to the fixed 3-bit "100" detector FSM.
- Pattern length is set at build time; pattern value is loaded at run time.
- Adds a valid qualifier, overlap / non-overlap mode, a saturating match counter and a Moore-style registered match pulse.
- Sits on serial data paths (UART/SPI bit streams) ahead of frame-sync and control logic.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  system clock; all state updates on the posedge.
- reset  in  1  asynchronous, active-high reset.
- serialInput  in  1  serial data bit.
- in_valid  in  1  qualifies serialInput; the bit is sampled only when in_valid=1.
- pattern  in  PAT_LEN  pattern value. pattern[PAT_LEN-1] is compared against the oldest bit, pattern[0] against the newest.
- pattern_load  in  1  latches pattern into pat_reg and restarts the search.
- overlap_en  in  1  1 = overlapping matches allowed; 0 = history is discarded after each match.
- count_clear  in  1  synchronous clear of match_count.
- out  out  1  one-cycle match pulse.
- match_count  out  CNT_W  number of matches, saturating.
- armed  out  1  high when the state is SEARCH.

Behaviour:
- Reset values:
  - state=IDLE; pat_reg=0; shift history=0; fill counter=0.
  - out=0; match_count=0; armed=0.
- Internal registers:
  - shift register hist[PAT_LEN-1:0].
  - fill counter, 0..PAT_LEN.
  - 3-state FSM: IDLE, FILL, SEARCH.
- IDLE:
  - Input bits are ignored.
  - pattern_load=1 -> pat_reg<=pattern, hist<=0, fill<=0, go to FILL.
- FILL:
  - On each valid bit: hist<={hist[PAT_LEN-2:0], serialInput}, fill<=fill+1.
  - When fill reaches PAT_LEN on this edge, go to SEARCH and perform the compare on the same edge.
- SEARCH:
  - On each valid bit: shift hist, then compare the new hist value with pat_reg.
  - A hit sets out_r<=1 for exactly one cycle.
- Match latency:
  - out=out_r is registered.
  - out is high in the cycle after the edge that sampled the completing bit. This is identical timing to the legacy detector's Moore output.
  - out=0 in every cycle where no completing bit was sampled, including cycles with in_valid=0.
- After a hit:
  - overlap_en=1: stay in SEARCH; hist is kept, so overlapping matches are detected.
  - overlap_en=0: hist<=0, fill<=0, go to FILL; the next match needs PAT_LEN fresh valid bits.
- in_valid=0: hist, fill and FSM state hold.
- pattern_load priority:
  - pattern_load in any state has priority over a same-cycle valid bit.
  - That bit is dropped; pat_reg reloads; hist and fill clear; next state is FILL; no out pulse.
- match_count:
  - Increments on each hit and saturates at 2^CNT_W-1.
  - count_clear has priority over a same-cycle increment; the result is 0.
  - match_count is unaffected by pattern_load.
- armed = (state==SEARCH).
- reset asserted mid-operation: all registers return to reset values immediately (asynchronous reset). A pattern_load is required before any further detection.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined:
  - Adds input pattern_mask [PAT_LEN-1:0], latched into mask_reg on pattern_load.
  - A bit with mask_reg[i]=0 is don't-care.
  - Hit condition: ((hist ^ pat_reg) & mask_reg)==0.
  - mask_reg resets to all ones.
- Undefined:
  - No pattern_mask port.
  - Hit requires an exact hist==pat_reg compare.

Test Plan:
- Legacy equivalence:
  - Setup: PAT_LEN=3, load 3'b100, overlap_en=1, in_valid=1.
  - Stimulus: stream 1,0,0,1,0,0,0.
  - Required: out pulses after bits 3 and 6 only; match_count=2.
- Overlap on:
  - Setup: PAT_LEN=4, load 4'b1010, overlap_en=1.
  - Stimulus: stream 1,0,1,0,1,0.
  - Required: out after bits 4 and 6; match_count=2.
- Overlap off:
  - Setup and stimulus: same as overlap on, with overlap_en=0.
  - Required: out after bit 4 only; match_count=1; FSM in FILL with fill=2 at the end.
- in_valid gaps:
  - Setup: PAT_LEN=3, load 3'b100.
  - Stimulus: bits 1,0,0 with 2 idle cycles (in_valid=0) between each.
  - Required: single out pulse exactly one cycle after the edge sampling the final 0; out=0 during idle cycles.
- Load/clear priority and reset:
  - pattern_load coincident with a completing bit -> no pulse, armed=0, fill=0.
  - count_clear coincident with a hit -> match_count=0.
  - match_count at 255 with CNT_W=8 plus a further hit -> stays 255.
  - reset asserted mid-stream -> out=0, match_count=0, armed=0 without waiting for a clock edge.
- Mask (SEQ_DET_MASK_EN defined):
  - Setup: PAT_LEN=4, pattern 4'b1001, mask 4'b1001.
  - Stimulus: streams 1,1,1,1 and 1,0,0,1.
  - Required: out pulses for both streams.
